// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA keystream generation and decrypt stage.
// Walks the PRGA over the scrambled S-box in s_RAM, keeps swapping entries,
// XORs each keystream byte with the ciphertext ROM and writes plaintext out.
// Outputs are registered from the next-state/next-data decode, so every
// memory-facing signal is valid for the whole of the state it belongs to.
module rc4_prga_decrypt #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [7:0] out_address,
  output logic [7:0] out_data,
  output logic       out_wren
);

  localparam int unsigned W = 8;
  localparam logic [W-1:0] LAST_K = W'(MSG_LEN - 1);

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    INC_I,
    RD_SI_A,
    RD_SI_B,
    CALC_J,
    RD_SJ_A,
    RD_SJ_B,
    WR_SI,
    WR_SJ,
    RD_F_A,
    RD_F_B,
    RD_ROM_A,
    RD_ROM_B,
    WR_OUT,
    NEXT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [W-1:0] i, j, k, si, sj, f, enc;
  logic [W-1:0] i_nxt, j_nxt, k_nxt, si_nxt, sj_nxt, f_nxt, enc_nxt;

  logic         done_nxt;
  logic [W-1:0] s_address_nxt;
  logic [W-1:0] s_data_nxt;
  logic         s_wren_nxt;
  logic [W-1:0] rom_address_nxt;
  logic [W-1:0] out_address_nxt;
  logic [W-1:0] out_data_nxt;
  logic         out_wren_nxt;

  // State register
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state sequencing: one byte every 14 states
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = INIT;
      INIT:     state_next = INC_I;
      INC_I:    state_next = RD_SI_A;
      RD_SI_A:  state_next = RD_SI_B;
      RD_SI_B:  state_next = CALC_J;
      CALC_J:   state_next = RD_SJ_A;
      RD_SJ_A:  state_next = RD_SJ_B;
      RD_SJ_B:  state_next = WR_SI;
      WR_SI:    state_next = WR_SJ;
      WR_SJ:    state_next = RD_F_A;
      RD_F_A:   state_next = RD_F_B;
      RD_F_B:   state_next = RD_ROM_A;
      RD_ROM_A: state_next = RD_ROM_B;
      RD_ROM_B: state_next = WR_OUT;
      WR_OUT:   state_next = NEXT;
      NEXT:     state_next = (k == LAST_K) ? DONE : INC_I;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath register updates; index arithmetic wraps mod 256
  always_comb begin
    i_nxt   = i;
    j_nxt   = j;
    k_nxt   = k;
    si_nxt  = si;
    sj_nxt  = sj;
    f_nxt   = f;
    enc_nxt = enc;
    case (state)
      INIT: begin
        i_nxt = '0;
        j_nxt = '0;
        k_nxt = '0;
      end
      INC_I:    i_nxt   = W'(i + 8'd1);
      RD_SI_B:  si_nxt  = s_q;
      CALC_J:   j_nxt   = W'(j + si);
      RD_SJ_B:  sj_nxt  = s_q;
      RD_F_B:   f_nxt   = s_q;
      RD_ROM_B: enc_nxt = rom_q;
      NEXT:     if (k != LAST_K) k_nxt = W'(k + 8'd1);
      default:  ;
    endcase
  end

  // Output decode for the state being entered, using the values it will see
  always_comb begin
    done_nxt        = 1'b0;
    s_address_nxt   = '0;
    s_data_nxt      = '0;
    s_wren_nxt      = 1'b0;
    rom_address_nxt = k_nxt;
    out_address_nxt = k_nxt;
    out_data_nxt    = '0;
    out_wren_nxt    = 1'b0;
    case (state_next)
      RD_SI_A, RD_SI_B: s_address_nxt = i_nxt;
      RD_SJ_A, RD_SJ_B: s_address_nxt = j_nxt;
      WR_SI: begin
        s_address_nxt = i_nxt;
        s_data_nxt    = sj_nxt;
        s_wren_nxt    = 1'b1;
      end
      WR_SJ: begin
        s_address_nxt = j_nxt;
        s_data_nxt    = si_nxt;
        s_wren_nxt    = 1'b1;
      end
      RD_F_A, RD_F_B: s_address_nxt = W'(si_nxt + sj_nxt);
      WR_OUT: begin
        out_data_nxt = f_nxt ^ enc_nxt;
        out_wren_nxt = 1'b1;
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (i_reset) begin
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      f           <= '0;
      enc         <= '0;
      done        <= 1'b0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      out_address <= '0;
      out_data    <= '0;
      out_wren    <= 1'b0;
    end else begin
      i           <= i_nxt;
      j           <= j_nxt;
      k           <= k_nxt;
      si          <= si_nxt;
      sj          <= sj_nxt;
      f           <= f_nxt;
      enc         <= enc_nxt;
      done        <= done_nxt;
      s_address   <= s_address_nxt;
      s_data      <= s_data_nxt;
      s_wren      <= s_wren_nxt;
      rom_address <= rom_address_nxt;
      out_address <= out_address_nxt;
      out_data    <= out_data_nxt;
      out_wren    <= out_wren_nxt;
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: synchronous memory models, an RC4 reference
// model feeding a scoreboard queue, a vector table, and hand-written
// sequences for start-held, mid-pass reset and MSG_LEN=1.
module tb_rc4_prga_decrypt;

  localparam int LEN = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       i_reset, start, start1, load_s, load_s1;

  logic       done, s_wren, out_wren;
  logic [7:0] s_address, s_data, s_q, rom_address, rom_q, out_address, out_data;
  logic       done1, s_wren1, out_wren1;
  logic [7:0] s_address1, s_data1, s_q1, rom_address1, rom_q1, out_address1, out_data1;

  logic [7:0] s_init [256];
  logic [7:0] s_mem  [256];
  logic [7:0] s1_mem [256];
  logic [7:0] rom_mem[256];
  logic [7:0] s_areg, rom_areg, s1_areg, rom1_areg;

  rc4_prga_decrypt #(.MSG_LEN(LEN)) dut (
    .clock(clock), .i_reset(i_reset), .start(start), .done(done),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .out_address(out_address), .out_data(out_data), .out_wren(out_wren)
  );

  rc4_prga_decrypt #(.MSG_LEN(1)) dut1 (
    .clock(clock), .i_reset(i_reset), .start(start1), .done(done1),
    .s_address(s_address1), .s_data(s_data1), .s_wren(s_wren1), .s_q(s_q1),
    .rom_address(rom_address1), .rom_q(rom_q1),
    .out_address(out_address1), .out_data(out_data1), .out_wren(out_wren1)
  );

  // Synchronous RAM/ROM models: registered address, unregistered q
  always @(posedge clock) begin
    s_areg    <= s_address;
    rom_areg  <= rom_address;
    s1_areg   <= s_address1;
    rom1_areg <= rom_address1;
    if (load_s) begin
      for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
    end else if (s_wren) begin
      s_mem[s_address] <= s_data;
    end
    if (load_s1) begin
      for (int n = 0; n < 256; n++) s1_mem[n] <= s_init[n];
    end else if (s_wren1) begin
      s1_mem[s_address1] <= s_data1;
    end
  end
  assign s_q    = s_mem[s_areg];
  assign rom_q  = rom_mem[rom_areg];
  assign s_q1   = s1_mem[s1_areg];
  assign rom_q1 = rom_mem[rom1_areg];

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent RC4 PRGA reference over s_init/rom_mem
  task automatic model_pass(input int len);
    logic [7:0] ms[256];
    logic [7:0] mi, mj, t;
    for (int n = 0; n < 256; n++) ms[n] = s_init[n];
    mi = 8'd0;
    mj = 8'd0;
    for (int kk = 0; kk < len; kk++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      t = ms[mi] + ms[mj];
      exp_q.push_back({8'(kk), ms[t] ^ rom_mem[kk]});
    end
  endtask

  task automatic fill_sbox(input int kind);
    for (int n = 0; n < 256; n++) begin
      case (kind)
        0:       s_init[n] = 8'(n);
        1:       s_init[n] = 8'h80;
        default: s_init[n] = 8'(255 - n);
      endcase
    end
  endtask

  task automatic fill_rom(input logic [7:0] base, input logic [7:0] step);
    for (int n = 0; n < 256; n++) rom_mem[n] = 8'(base + 8'(n) * step);
  endtask

  task automatic load_main();
    @(negedge clock); load_s = 1'b1;
    @(negedge clock); load_s = 1'b0;
  endtask

  // Drives a start pulse (or held start) and observes up to max_n cycles
  logic [7:0] got[3];
  logic [7:0] snap2, snap3, snap5;
  int cyc_done, n_done, n_sw, n_ow;

  task automatic run_pass(input bit hold, input int max_n);
    cyc_done = -1; n_done = 0; n_sw = 0; n_ow = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = hold;
    for (int n = 1; n <= max_n; n++) begin
      if (s_wren) n_sw++;
      if (out_wren) begin
        n_ow++;
        if (out_address < 8'd3) got[out_address[1:0]] = out_data;
        if (out_address == 8'd2) begin
          snap2 = s_mem[2]; snap3 = s_mem[3]; snap5 = s_mem[5];
        end
        if (exp_q.size() == 0) begin
          check("unexpected_out_write", 1, 0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("out_address", int'(out_address), int'(e[15:8]));
          check("out_data", int'(out_data), int'(e[7:0]));
        end
      end
      if (done) begin
        n_done++;
        if (cyc_done < 0) cyc_done = n;
        start = 1'b0;
      end
      if (n < max_n) @(negedge clock);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int         sbox_kind;
    logic [7:0] rom_base;
    logic [7:0] rom_step;
    bit         chk_first;
    logic [7:0] e0, e1, e2;
    bit         chk_snap;
    bit         hold;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{0, 8'h00, 8'h00, 1'b1, 8'h02, 8'h05, 8'h07, 1'b1, 1'b0};
    vecs[1] = '{0, 8'hFF, 8'h00, 1'b1, 8'hFD, 8'hFA, 8'hF8, 1'b0, 1'b1};
    vecs[2] = '{1, 8'h11, 8'h07, 1'b1, 8'h91, 8'h98, 8'h9F, 1'b0, 1'b0};
    vecs[3] = '{2, 8'h5A, 8'h03, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

    i_reset = 1'b1; start = 1'b0; start1 = 1'b0; load_s = 1'b0; load_s1 = 1'b0;
    fill_sbox(0);
    fill_rom(8'h00, 8'h00);
    repeat (3) @(negedge clock);

    // Reset state of every output
    check("rst_done", int'(done), 0);
    check("rst_s_wren", int'(s_wren), 0);
    check("rst_out_wren", int'(out_wren), 0);
    check("rst_s_address", int'(s_address), 0);
    check("rst_s_data", int'(s_data), 0);
    check("rst_rom_address", int'(rom_address), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst1_done", int'(done1), 0);
    i_reset = 1'b0;

    // Vector table, each pass against the scoreboard
    for (int v = 0; v < 4; v++) begin
      fill_sbox(vecs[v].sbox_kind);
      fill_rom(vecs[v].rom_base, vecs[v].rom_step);
      load_main();
      exp_q.delete();
      model_pass(LEN);
      run_pass(vecs[v].hold, 460);
      check("done_cycle", cyc_done, 450);
      check("done_pulses", n_done, 1);
      check("s_wren_cycles", n_sw, 2 * LEN);
      check("out_wren_cycles", n_ow, LEN);
      check("scoreboard_empty", exp_q.size(), 0);
      if (vecs[v].chk_first) begin
        check("out0", int'(got[0]), int'(vecs[v].e0));
        check("out1", int'(got[1]), int'(vecs[v].e1));
        check("out2", int'(got[2]), int'(vecs[v].e2));
      end
      if (vecs[v].chk_snap) begin
        check("snap_s2", int'(snap2), 8'h03);
        check("snap_s3", int'(snap3), 8'h05);
        check("snap_s5", int'(snap5), 8'h02);
      end
    end

    // Mid-pass reset at cycle 100
    fill_sbox(0);
    fill_rom(8'h00, 8'h00);
    load_main();
    exp_q.delete();
    model_pass(LEN);
    run_pass(1'b0, 100);
    i_reset = 1'b1;
    @(negedge clock);
    check("mid_rst_s_wren", int'(s_wren), 0);
    check("mid_rst_out_wren", int'(out_wren), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_s_address", int'(s_address), 0);
    i_reset = 1'b0;
    n_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done || s_wren || out_wren) n_done++;
    end
    check("post_rst_quiet", n_done, 0);

    // Fresh pass after the reset completes normally
    load_main();
    exp_q.delete();
    model_pass(LEN);
    run_pass(1'b0, 460);
    check("after_rst_done_cycle", cyc_done, 450);
    check("after_rst_done_pulses", n_done, 1);
    check("after_rst_out_wren", n_ow, LEN);
    check("after_rst_s_wren", n_sw, 2 * LEN);
    check("after_rst_out0", int'(got[0]), 8'h02);

    // MSG_LEN=1 instance: one write at address 0, done in cycle 16
    fill_sbox(0);
    fill_rom(8'h40, 8'h00);
    @(negedge clock); load_s1 = 1'b1;
    @(negedge clock); load_s1 = 1'b0; start1 = 1'b1;
    @(negedge clock); start1 = 1'b0;
    begin
      int c1_done, c1_ow, c1_sw;
      c1_done = -1; c1_ow = 0; c1_sw = 0;
      for (int n = 1; n <= 24; n++) begin
        if (out_wren1) begin
          c1_ow++;
          check("len1_out_address", int'(out_address1), 0);
          check("len1_out_data", int'(out_data1), 8'h42);
        end
        if (s_wren1) c1_sw++;
        if (done1 && c1_done < 0) c1_done = n;
        @(negedge clock);
      end
      check("len1_out_writes", c1_ow, 1);
      check("len1_s_writes", c1_sw, 2);
      check("len1_done_cycle", c1_done, 16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
